// File: rtl/gps_acq_controller_if.sv
// Correlator dwell handshake between gps_acq_controller (master) and the acquisition correlator (slave).
interface gps_acq_controller_if #(
  parameter int BIN_W    = 6,
  parameter int METRIC_W = 16,
  parameter int PHASE_W  = 10
) ();
  logic                corr_start_o;
  logic [4:0]          corr_prn_o;
  logic [BIN_W-1:0]    corr_bin_o;
  logic                corr_done_i;
  logic [METRIC_W-1:0] corr_metric_i;
  logic [PHASE_W-1:0]  corr_phase_i;

  modport master (output corr_start_o, corr_prn_o, corr_bin_o,
                  input  corr_done_i, corr_metric_i, corr_phase_i);
  modport slave  (input  corr_start_o, corr_prn_o, corr_bin_o,
                  output corr_done_i, corr_metric_i, corr_phase_i);
endinterface

// File: rtl/gps_acq_controller.sv
// gps_acq_controller: one-PRN Doppler sweep, peak confirm, lock/timeout reporting.
// Optional macro ACQ_PHASE_CHECK_EN: confirm dwells must also sit within +/-1 chip (circular) of the search peak.
module gps_acq_controller #(
  parameter int N_BINS        = 41,
  parameter int BIN_W         = 6,
  parameter int METRIC_W      = 16,
  parameter int PHASE_W       = 10,
  parameter int CONFIRM_COUNT = 3,
  parameter int MAX_SWEEPS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [4:0]          prn_i,
  input  logic [METRIC_W-1:0] thresh_i,
  gps_acq_controller_if.master corr,
  output logic [2:0]          state_o,
  output logic                locked_o,
  output logic                timeout_o,
  output logic [BIN_W-1:0]    lock_bin_o,
  output logic [PHASE_W-1:0]  lock_phase_o,
  output logic [METRIC_W-1:0] lock_metric_o
);
  typedef enum logic [2:0] {
    ACQ_IDLE = 3'd0, ACQ_SEARCH = 3'd1, ACQ_CONFIRM = 3'd2, ACQ_LOCKED = 3'd3, ACQ_TIMEOUT = 3'd4
  } acq_state_e;

  localparam int SW_W     = (MAX_SWEEPS > 1) ? $clog2(MAX_SWEEPS) : 1;
  localparam int CC_W     = $clog2(CONFIRM_COUNT + 1);
  localparam int CODE_LEN = 1023;
  localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(N_BINS - 1);
  localparam logic [SW_W-1:0]  LAST_SWEEP = SW_W'(MAX_SWEEPS - 1);
  localparam logic [CC_W-1:0]  CC_LAST    = CC_W'(CONFIRM_COUNT - 1);

  acq_state_e          state;
  logic [METRIC_W-1:0] thresh;
  logic [SW_W-1:0]     sweep;
  logic [CC_W-1:0]     conf_cnt;
  logic                outstanding, drain;

  logic                done_ok, drain_done, start_ok, new_best, phase_ok, pass, sweep_fail;
  logic [METRIC_W-1:0] cand_metric;
  logic [BIN_W-1:0]    cand_bin;
  logic [PHASE_W-1:0]  cand_phase;

  assign state_o = state;

`ifdef ACQ_PHASE_CHECK_EN
  logic [PHASE_W-1:0] pdiff;
  always_comb begin
    pdiff    = (corr.corr_phase_i >= lock_phase_o) ? corr.corr_phase_i - lock_phase_o
                                                   : lock_phase_o - corr.corr_phase_i;
    // 1022 apart on a 1023-chip code is one chip across the wrap
    phase_ok = (pdiff <= PHASE_W'(1)) || (pdiff == PHASE_W'(CODE_LEN - 1));
  end
`else
  assign phase_ok = 1'b1;
`endif

  always_comb begin
    done_ok     = corr.corr_done_i && outstanding && !drain;
    drain_done  = corr.corr_done_i && outstanding && drain;
    start_ok    = start_i && (state == ACQ_IDLE || state == ACQ_LOCKED || state == ACQ_TIMEOUT);
    new_best    = corr.corr_metric_i > lock_metric_o;
    cand_metric = new_best ? corr.corr_metric_i : lock_metric_o;
    cand_bin    = new_best ? corr.corr_bin_o    : lock_bin_o;
    cand_phase  = new_best ? corr.corr_phase_i  : lock_phase_o;
    pass        = (corr.corr_metric_i >= thresh) && phase_ok;
    sweep_fail  = done_ok && ((state == ACQ_SEARCH && corr.corr_bin_o == LAST_BIN && cand_metric < thresh) ||
                              (state == ACQ_CONFIRM && !pass));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ACQ_IDLE;
      thresh            <= '0;
      sweep             <= '0;
      conf_cnt          <= '0;
      outstanding       <= 1'b0;
      drain             <= 1'b0;
      locked_o          <= 1'b0;
      timeout_o         <= 1'b0;
      lock_bin_o        <= '0;
      lock_phase_o      <= '0;
      lock_metric_o     <= '0;
      corr.corr_start_o <= 1'b0;
      corr.corr_prn_o   <= '0;
      corr.corr_bin_o   <= '0;
    end else begin
      corr.corr_start_o <= 1'b0;
      // any done retires the single outstanding dwell; later issues in this block re-arm it
      if (corr.corr_done_i) outstanding <= 1'b0;
      if (abort_i) begin
        state     <= ACQ_IDLE;
        locked_o  <= 1'b0;
        timeout_o <= 1'b0;
        drain     <= outstanding && !corr.corr_done_i;
      end else if (start_ok) begin
        state           <= ACQ_SEARCH;
        locked_o        <= 1'b0;
        timeout_o       <= 1'b0;
        corr.corr_prn_o <= prn_i;
        thresh          <= thresh_i;
        sweep           <= '0;
        conf_cnt        <= '0;
        lock_bin_o      <= '0;
        lock_phase_o    <= '0;
        lock_metric_o   <= '0;
        drain           <= drain && !corr.corr_done_i;
        // an aborted dwell still in flight holds off the first request
        if (!drain || corr.corr_done_i) begin
          corr.corr_start_o <= 1'b1;
          outstanding       <= 1'b1;
          corr.corr_bin_o   <= '0;
        end
      end else if (drain_done) begin
        drain <= 1'b0;
        if (state == ACQ_SEARCH) begin
          corr.corr_start_o <= 1'b1;
          outstanding       <= 1'b1;
          corr.corr_bin_o   <= '0;
        end
      end else if (sweep_fail) begin
        conf_cnt <= '0;
        if (sweep == LAST_SWEEP) begin
          state     <= ACQ_TIMEOUT;
          timeout_o <= 1'b1;
        end else begin
          state             <= ACQ_SEARCH;
          sweep             <= sweep + 1'b1;
          lock_bin_o        <= '0;
          lock_phase_o      <= '0;
          lock_metric_o     <= '0;
          corr.corr_start_o <= 1'b1;
          outstanding       <= 1'b1;
          corr.corr_bin_o   <= '0;
        end
      end else if (done_ok) begin
        if (state == ACQ_SEARCH) begin
          lock_bin_o        <= cand_bin;
          lock_phase_o      <= cand_phase;
          lock_metric_o     <= cand_metric;
          corr.corr_start_o <= 1'b1;
          outstanding       <= 1'b1;
          if (corr.corr_bin_o != LAST_BIN) begin
            corr.corr_bin_o <= corr.corr_bin_o + BIN_W'(1);
          end else begin
            state           <= ACQ_CONFIRM;
            conf_cnt        <= '0;
            corr.corr_bin_o <= cand_bin;
          end
        end else if (conf_cnt == CC_LAST) begin
          state    <= ACQ_LOCKED;
          locked_o <= 1'b1;
        end else begin
          conf_cnt          <= conf_cnt + 1'b1;
          corr.corr_start_o <= 1'b1;
          outstanding       <= 1'b1;
          corr.corr_bin_o   <= lock_bin_o;
        end
      end
    end
  end
endmodule
